// File: rtl/debug_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug memory engine.
package debug_ocimem_pkg;

    // Engine states: waiting for a command, reading a word, writing a word.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } ocimem_state_t;

    localparam int unsigned JDO_W         = 38;
    localparam int unsigned WORD_W        = 32;

    // Field positions inside the jdo word from the debug slave.
    localparam int unsigned JDO_RD_BIT    = 35;
    localparam int unsigned JDO_ADDR_LSB  = 18;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/debug_ocimem_ctrl.sv
// Debug-side single-word Avalon-MM read/write engine driven by the
// debug slave's ocimem command pulses. Returns read data plus
// ready/error status to the JTAG side.
module debug_ocimem_ctrl
    import debug_ocimem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    output logic [ADDR_W+1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [WORD_W-1:0]   avm_writedata,
    input  logic [WORD_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest,
    output logic [WORD_W-1:0]   MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    ocimem_state_t     r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_mon;
    logic              r_ready;
    logic              r_error;
    logic              r_read;
    logic              r_write;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_drop;

    ocimem_state_t     w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [WORD_W-1:0] w_wdata_nxt;
    logic [WORD_W-1:0] w_mon_nxt;
    logic              w_ready_nxt;
    logic              w_error_nxt;
    logic              w_read_nxt;
    logic              w_write_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_drop_nxt;

    logic              w_cmd_any;
    logic              w_unused_jdo;

    assign w_cmd_any    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    // Command bits that carry nothing this engine needs.
    assign w_unused_jdo = &{1'b0, jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    // The word address is kept as a register; the byte address is derived.
    assign avm_address   = {r_addr, 2'b00};
    assign avm_read      = r_read;
    assign avm_write     = r_write;
    assign avm_writedata = r_wdata;
    assign MonDReg       = r_mon;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

    // State and datapath registers; all return to zero/IDLE on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mon   <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_cnt   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_mon   <= w_mon_nxt;
            r_ready <= w_ready_nxt;
            r_error <= w_error_nxt;
            r_read  <= w_read_nxt;
            r_write <= w_write_nxt;
            r_cnt   <= w_cnt_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Next-state and next-output logic for command decode and transfers.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_mon_nxt   = r_mon;
        w_ready_nxt = r_ready;
        w_error_nxt = r_error;
        w_read_nxt  = r_read;
        w_write_nxt = r_write;
        w_cnt_nxt   = r_cnt;
        w_drop_nxt  = r_drop;

        case (r_state)
            ST_IDLE: begin
                // Wait counter and busy-drop flag start fresh for every transfer.
                w_cnt_nxt  = '0;
                w_drop_nxt = 1'b0;
                if (take_action_ocimem_a) begin
                    w_addr_nxt  = jdo[JDO_ADDR_LSB +: ADDR_W];
                    w_error_nxt = 1'b0;
                    if (jdo[JDO_RD_BIT]) begin
                        w_state_nxt = ST_RD;
                        w_read_nxt  = 1'b1;
                        w_ready_nxt = 1'b0;
                    end else begin
                        // Address-only load completes immediately.
                        w_ready_nxt = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    w_wdata_nxt = jdo[JDO_WDATA_LSB +: WORD_W];
                    w_state_nxt = ST_WR;
                    w_write_nxt = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_error_nxt = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_state_nxt = ST_RD;
                    w_read_nxt  = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_error_nxt = 1'b0;
                end
            end

            ST_RD: begin
                // Commands arriving while busy are discarded but remembered.
                if (w_cmd_any) begin
                    w_drop_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    w_mon_nxt   = avm_readdata;
                    w_ready_nxt = 1'b1;
                    w_error_nxt = r_drop | w_cmd_any;
                    w_read_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    // Abandon the read; data and address stay as they were.
                    w_ready_nxt = 1'b0;
                    w_error_nxt = 1'b1;
                    w_read_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            ST_WR: begin
                if (w_cmd_any) begin
                    w_drop_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    // Post-increment so consecutive writes fill successive words.
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_ready_nxt = 1'b1;
                    w_error_nxt = r_drop | w_cmd_any;
                    w_write_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_ready_nxt = 1'b0;
                    w_error_nxt = 1'b1;
                    w_write_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Self-checking bench for debug_ocimem_ctrl: directed scenarios plus a
// randomized command stream checked against a per-command reference model.
module tb_debug_ocimem_ctrl;

    localparam int TMO = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        take_a = 1'b0;
    logic        take_na = 1'b0;
    logic        take_b = 1'b0;
    logic [9:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, advanced one whole command at a time.
    logic [7:0]  m_addr;
    logic [31:0] m_mon;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_err;

    debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(TMO)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_no_action_ocimem_a (take_na),
        .take_action_ocimem_b    (take_b),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] a);
        logic [37:0] j;
        j = 38'($urandom);
        j[35] = rd;
        j[25:18] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j = 38'($urandom);
        j[34:3] = d;
        return j;
    endfunction

    // Issue one command pulse (kind = {a, b, no_action_a}) and act as an
    // Avalon slave that stalls for 'waits' cycles. Reports what was seen.
    task automatic run_cmd(input logic [2:0] kind, input logic [37:0] j, input int waits,
                           input logic [31:0] rd, output int ncyc, output logic [9:0] o_addr,
                           output logic [31:0] o_wd, output logic o_rd, output logic o_wr,
                           output logic stable);
        jdo = j;
        take_a = kind[2];
        take_b = kind[1];
        take_na = kind[0];
        avm_readdata = rd;
        avm_waitrequest = 1'b0;
        cyc();
        take_a = 1'b0;
        take_b = 1'b0;
        take_na = 1'b0;
        jdo = {6'($urandom), 32'($urandom)};
        ncyc = 0;
        o_addr = avm_address;
        o_wd = avm_writedata;
        o_rd = avm_read;
        o_wr = avm_write;
        stable = 1'b1;
        while ((avm_read || avm_write) && ncyc < 600) begin
            if (avm_address !== o_addr || avm_writedata !== o_wd ||
                avm_read !== o_rd || avm_write !== o_wr) stable = 1'b0;
            ncyc++;
            avm_waitrequest = (ncyc <= waits);
            cyc();
        end
        avm_waitrequest = 1'b0;
    endtask

    // Expected effect of one command, written from the command rules.
    task automatic model_cmd(input logic [2:0] kind, input logic [37:0] j, input int waits,
                             input logic [31:0] rd, output int e_ncyc, output logic [9:0] e_addr,
                             output logic e_rd, output logic e_wr);
        bit tmo;
        tmo = (waits > TMO);
        e_rd = 1'b0;
        e_wr = 1'b0;
        e_ncyc = 0;
        if (kind[2]) begin
            m_addr = j[25:18];
            e_addr = {m_addr, 2'b00};
            if (j[35]) e_rd = 1'b1;
        end else if (kind[1]) begin
            m_wdata = j[34:3];
            e_addr = {m_addr, 2'b00};
            e_wr = 1'b1;
        end else begin
            m_addr = m_addr + 8'd1;
            e_addr = {m_addr, 2'b00};
            e_rd = 1'b1;
        end
        if (e_rd || e_wr) begin
            e_ncyc = tmo ? TMO + 1 : waits + 1;
            m_ready = !tmo;
            m_err = tmo;
            if (!tmo && e_rd) m_mon = rd;
            if (!tmo && e_wr) m_addr = m_addr + 8'd1;
        end else begin
            m_ready = 1'b1;
            m_err = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n_checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin n_fail++;
            $display("FAIL reset_strobes: got rd=%b wr=%b, required 0/0", avm_read, avm_write); end
        n_checks++; if (avm_address !== 10'h000) begin n_fail++;
            $display("FAIL reset_address: got %h, required 000", avm_address); end
        n_checks++; if (avm_writedata !== 32'h0 || MonDReg !== 32'h0) begin n_fail++;
            $display("FAIL reset_data: got wd=%h mon=%h, required 0/0", avm_writedata, MonDReg); end
        n_checks++; if (monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin n_fail++;
            $display("FAIL reset_status: got rdy=%b err=%b, required 0/0", monitor_ready, monitor_error); end
        m_addr = '0; m_mon = '0; m_wdata = '0; m_ready = 1'b0; m_err = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        int n, en; logic [9:0] a, ea; logic [31:0] wd; logic r, w, s, er, ew;
        model_cmd(3'b100, mk_a(1'b1, 8'h10), 0, 32'hDEADBEEF, en, ea, er, ew);
        run_cmd(3'b100, mk_a(1'b1, 8'h10), 0, 32'hDEADBEEF, n, a, wd, r, w, s);
        n_checks++; if (r !== 1'b1 || w !== 1'b0 || a !== 10'h040) begin n_fail++;
            $display("FAIL rd0_request: got rd=%b wr=%b addr=%h, required 1/0/040", r, w, a); end
        n_checks++; if (n !== 1) begin n_fail++;
            $display("FAIL rd0_latency: got %0d strobe cycles, required 1", n); end
        n_checks++; if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin n_fail++;
            $display("FAIL rd0_result: got mon=%h rdy=%b err=%b, required deadbeef/1/0", MonDReg, monitor_ready, monitor_error); end
    endtask

    task automatic test_write_wrap();
        int n, en; logic [9:0] a, ea; logic [31:0] wd; logic r, w, s, er, ew; logic [37:0] j;
        j = mk_a(1'b0, 8'hFF);
        model_cmd(3'b100, j, 0, 32'h0, en, ea, er, ew);
        run_cmd(3'b100, j, 0, 32'h0, n, a, wd, r, w, s);
        n_checks++; if (n !== 0 || monitor_ready !== 1'b1 || avm_address !== 10'h3FC) begin n_fail++;
            $display("FAIL load_addr: got cyc=%0d rdy=%b addr=%h, required 0/1/3fc", n, monitor_ready, avm_address); end
        j = mk_b(32'h11111111);
        model_cmd(3'b010, j, 0, 32'h0, en, ea, er, ew);
        run_cmd(3'b010, j, 0, 32'h0, n, a, wd, r, w, s);
        n_checks++; if (w !== 1'b1 || a !== 10'h3FC || wd !== 32'h11111111 || n !== 1) begin n_fail++;
            $display("FAIL wr_ff: got wr=%b addr=%h data=%h cyc=%0d, required 1/3fc/11111111/1", w, a, wd, n); end
        j = mk_b(32'h22222222);
        model_cmd(3'b010, j, 2, 32'h0, en, ea, er, ew);
        run_cmd(3'b010, j, 2, 32'h0, n, a, wd, r, w, s);
        n_checks++; if (w !== 1'b1 || a !== 10'h000 || wd !== 32'h22222222 || s !== 1'b1) begin n_fail++;
            $display("FAIL wr_wrap: got wr=%b addr=%h data=%h stable=%b, required 1/000/22222222/1", w, a, wd, s); end
        n_checks++; if (monitor_ready !== 1'b1 || avm_address !== 10'h004) begin n_fail++;
            $display("FAIL wr_post_inc: got rdy=%b addr=%h, required 1/004", monitor_ready, avm_address); end
    endtask

    task automatic test_read_next_wait();
        int n, en; logic [9:0] a, ea; logic [31:0] wd; logic r, w, s, er, ew; logic [37:0] j;
        j = mk_a(1'b0, 8'h05);
        model_cmd(3'b100, j, 0, 32'h0, en, ea, er, ew);
        run_cmd(3'b100, j, 0, 32'h0, n, a, wd, r, w, s);
        model_cmd(3'b001, 38'h0, 3, 32'h12345678, en, ea, er, ew);
        run_cmd(3'b001, 38'h0, 3, 32'h12345678, n, a, wd, r, w, s);
        n_checks++; if (r !== 1'b1 || a !== 10'h018 || s !== 1'b1) begin n_fail++;
            $display("FAIL rdnext_req: got rd=%b addr=%h stable=%b, required 1/018/1", r, a, s); end
        n_checks++; if (n !== 4 || MonDReg !== 32'h12345678 || monitor_ready !== 1'b1) begin n_fail++;
            $display("FAIL rdnext_done: got cyc=%0d mon=%h rdy=%b, required 4/12345678/1", n, MonDReg, monitor_ready); end
    endtask

    task automatic test_timeout();
        int n, en; logic [9:0] a, ea; logic [31:0] wd; logic r, w, s, er, ew; logic [31:0] mon0; logic [37:0] j;
        mon0 = MonDReg;
        model_cmd(3'b001, 38'h0, 1000, 32'hCAFEF00D, en, ea, er, ew);
        run_cmd(3'b001, 38'h0, 1000, 32'hCAFEF00D, n, a, wd, r, w, s);
        n_checks++; if (n !== TMO + 1) begin n_fail++;
            $display("FAIL tmo_rd_len: got %0d strobe cycles, required %0d", n, TMO + 1); end
        n_checks++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b0 || MonDReg !== mon0 || avm_read !== 1'b0) begin n_fail++;
            $display("FAIL tmo_rd_status: got err=%b rdy=%b mon=%h rd=%b, required 1/0/%h/0", monitor_error, monitor_ready, MonDReg, avm_read, mon0); end
        n_checks++; if (avm_address !== ea) begin n_fail++;
            $display("FAIL tmo_rd_addr: got %h, required %h", avm_address, ea); end
        j = mk_b(32'h5A5A0F0F);
        model_cmd(3'b010, j, 1000, 32'h0, en, ea, er, ew);
        run_cmd(3'b010, j, 1000, 32'h0, n, a, wd, r, w, s);
        n_checks++; if (n !== TMO + 1 || monitor_error !== 1'b1 || monitor_ready !== 1'b0 || avm_address !== ea) begin n_fail++;
            $display("FAIL tmo_wr: got cyc=%0d err=%b rdy=%b addr=%h, required %0d/1/0/%h", n, monitor_error, monitor_ready, avm_address, TMO + 1, ea); end
    endtask

    task automatic test_busy_drop();
        logic saw_wr;
        jdo = mk_a(1'b1, 8'h20);
        take_a = 1'b1;
        cyc();
        take_a = 1'b0;
        avm_waitrequest = 1'b1;
        saw_wr = avm_write;
        jdo = mk_b(32'hA5A5A5A5);
        take_b = 1'b1;
        cyc();
        take_b = 1'b0;
        saw_wr |= avm_write;
        cyc();
        saw_wr |= avm_write;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'h0BADF00D;
        cyc();
        m_addr = 8'h20; m_mon = 32'h0BADF00D; m_ready = 1'b1; m_err = 1'b1;
        n_checks++; if (saw_wr !== 1'b0 || avm_write !== 1'b0 || avm_read !== 1'b0) begin n_fail++;
            $display("FAIL busy_nowrite: got saw_wr=%b wr=%b rd=%b, required 0/0/0", saw_wr, avm_write, avm_read); end
        n_checks++; if (MonDReg !== m_mon || monitor_ready !== 1'b1 || monitor_error !== 1'b1) begin n_fail++;
            $display("FAIL busy_status: got mon=%h rdy=%b err=%b, required %h/1/1", MonDReg, monitor_ready, monitor_error, m_mon); end
        n_checks++; if (avm_writedata !== m_wdata || avm_address !== 10'h080) begin n_fail++;
            $display("FAIL busy_state: got wd=%h addr=%h, required %h/080", avm_writedata, avm_address, m_wdata); end
    endtask

    task automatic test_priority();
        int n, en; logic [9:0] a, ea; logic [31:0] wd; logic r, w, s, er, ew; logic [37:0] j;
        logic [2:0] kinds [3];
        kinds[0] = 3'b110; kinds[1] = 3'b011; kinds[2] = 3'b111;
        for (int k = 0; k < 3; k++) begin
            j = {6'($urandom), 32'($urandom)};
            model_cmd(kinds[k], j, 1, 32'h600D0000 | 32'(k), en, ea, er, ew);
            run_cmd(kinds[k], j, 1, 32'h600D0000 | 32'(k), n, a, wd, r, w, s);
            n_checks++; if (r !== er || w !== ew || n !== en || a !== ea || wd !== m_wdata) begin n_fail++;
                $display("FAIL prio_%0d: got rd=%b wr=%b cyc=%0d addr=%h wd=%h, required %b/%b/%0d/%h/%h",
                         k, r, w, n, a, wd, er, ew, en, ea, m_wdata); end
            n_checks++; if (MonDReg !== m_mon || monitor_ready !== m_ready || monitor_error !== m_err) begin n_fail++;
                $display("FAIL prio_%0d_status: got mon=%h rdy=%b err=%b, required %h/%b/%b",
                         k, MonDReg, monitor_ready, monitor_error, m_mon, m_ready, m_err); end
        end
    endtask

    task automatic test_random();
        int n, en, wt; logic [9:0] a, ea; logic [31:0] wd, rd; logic r, w, s, er, ew;
        logic [37:0] j; logic [2:0] kind;
        for (int it = 0; it < 60; it++) begin
            kind = 3'($urandom_range(1, 7));
            j = {6'($urandom), 32'($urandom)};
            wt = $urandom_range(0, 5);
            rd = $urandom;
            model_cmd(kind, j, wt, rd, en, ea, er, ew);
            run_cmd(kind, j, wt, rd, n, a, wd, r, w, s);
            n_checks++; if (r !== er || w !== ew || n !== en || a !== ea || wd !== m_wdata || s !== 1'b1) begin n_fail++;
                $display("FAIL rand_%0d_xfer: got rd=%b wr=%b cyc=%0d addr=%h wd=%h st=%b, required %b/%b/%0d/%h/%h/1",
                         it, r, w, n, a, wd, s, er, ew, en, ea, m_wdata); end
            n_checks++; if (MonDReg !== m_mon || monitor_ready !== m_ready || monitor_error !== m_err ||
                            avm_address !== {m_addr, 2'b00}) begin n_fail++;
                $display("FAIL rand_%0d_status: got mon=%h rdy=%b err=%b addr=%h, required %h/%b/%b/%h",
                         it, MonDReg, monitor_ready, monitor_error, avm_address, m_mon, m_ready, m_err, {m_addr, 2'b00}); end
        end
    endtask

    task automatic test_reset_mid_write();
        jdo = mk_b(32'h77777777);
        take_b = 1'b1;
        cyc();
        take_b = 1'b0;
        avm_waitrequest = 1'b1;
        cyc();
        cyc();
        n_checks++; if (avm_write !== 1'b1) begin n_fail++;
            $display("FAIL rstw_stalled: got wr=%b, required 1", avm_write); end
        reset = 1'b1;
        cyc();
        n_checks++; if (avm_write !== 1'b0 || avm_read !== 1'b0 || avm_address !== 10'h0) begin n_fail++;
            $display("FAIL rstw_strobe: got wr=%b rd=%b addr=%h, required 0/0/000", avm_write, avm_read, avm_address); end
        n_checks++; if (avm_writedata !== 32'h0 || MonDReg !== 32'h0 || monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin n_fail++;
            $display("FAIL rstw_values: got wd=%h mon=%h rdy=%b err=%b, required 0/0/0/0", avm_writedata, MonDReg, monitor_ready, monitor_error); end
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        m_addr = '0; m_mon = '0; m_wdata = '0; m_ready = 1'b0; m_err = 1'b0;
        cyc();
        n_checks++; if (avm_write !== 1'b0 || avm_address !== 10'h0) begin n_fail++;
            $display("FAIL rstw_idle: got wr=%b addr=%h, required 0/000", avm_write, avm_address); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wrap();
        test_read_next_wait();
        test_timeout();
        test_busy_drop();
        test_priority();
        test_random();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
